// File: rtl/tpu_pkg.sv
// Shared types and address map for the 2x2 systolic TPU control path.
package tpu_pkg;

   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned W_BASE    = 0;
   localparam int unsigned IN_BASE   = 4;
   localparam int unsigned LAST_ADDR = 7;
   localparam int unsigned OUT_BYTES = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CLEAR   = 3'd2,
      S_COMPUTE = 3'd3,
      S_OUTPUT  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/tpu_seq_counter.sv
// 3-bit up counter with synchronous load, enable and terminal-count compare.
module tpu_seq_counter
   import tpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              en,
   input  logic [ADDR_W-1:0] tc_val,
   output logic [ADDR_W-1:0] count,
   output logic              tc_c
);

   // Load has priority over increment; increment wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + ADDR_W'(1);
      end
   end

   assign tc_c = (count == tc_val);

endmodule

// File: rtl/tpu_sequencer.sv
// Job sequencer for the 2x2 systolic TPU: LOAD -> CLEAR -> COMPUTE -> OUTPUT.
// Optional weight reuse (skip addresses 0-3) is built when WEIGHT_REUSE_EN is defined.
module tpu_sequencer
   import tpu_pkg::*;
#(
   parameter int unsigned COMPUTE_CYCLES = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_en,
   input  logic       keep_w,
   input  logic       out_ready,
   output logic       mem_we,
   output logic [2:0] mem_addr,
   output logic       clear,
   output logic       mmu_en,
   output logic [2:0] mmu_cycle,
   output logic [1:0] res_sel,
   output logic       res_hi,
   output logic       out_valid,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(COMPUTE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
   localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(OUT_BYTES - 1);

   seq_state_e state_q, state_d;

   logic clear_d, mmu_en_d, out_valid_d, busy_d, done_d, overrun_d;

   logic [ADDR_W-1:0] addr_q, step_q, k_q;
   logic              addr_tc_c, step_tc_c, k_tc_c;
   logic              wr_ok_c, accept_c, step_en_c, step_wrap_c, addr_load_c;

   assign wr_ok_c     = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign mem_we      = rst_n && load_en && wr_ok_c;
   assign accept_c    = (state_q == S_OUTPUT) && out_ready;
   assign step_en_c   = (state_q == S_COMPUTE);
   assign step_wrap_c = step_en_c && step_tc_c;

`ifdef WEIGHT_REUSE_EN
   logic w_valid_q;
   logic reuse_c;

   // Reuse decision is taken on the job's first byte only, hence the IDLE qualifier.
   assign reuse_c     = keep_w && w_valid_q && (state_q == S_IDLE);
   assign addr_load_c = mem_we && reuse_c;
   assign mem_addr    = reuse_c ? ADDR_W'(IN_BASE) : addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_valid_q <= 1'b0;
      end else if (mem_we && (state_q == S_LOAD) && addr_tc_c) begin
         w_valid_q <= 1'b1;
      end
   end
`else
   logic unused_keep_w;

   assign unused_keep_w = keep_w;
   assign addr_load_c   = 1'b0;
   assign mem_addr      = addr_q;
`endif

   // Operand byte address: advances on every accepted write, wraps 7 -> 0.
   tpu_seq_counter u_addr_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (addr_load_c),
      .load_val (ADDR_W'(IN_BASE + 1)),
      .en       (mem_we),
      .tc_val   (ADDR_LAST),
      .count    (addr_q),
      .tc_c     (addr_tc_c)
   );

   // Compute step index: held at 0 through CLEAR, counts during COMPUTE.
   tpu_seq_counter u_step_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (step_wrap_c),
      .load_val ('0),
      .en       (step_en_c),
      .tc_val   (STEP_LAST),
      .count    (step_q),
      .tc_c     (step_tc_c)
   );

   // Output byte index k; only moves on a handshake so the select is stable under backpressure.
   tpu_seq_counter u_out_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (1'b0),
      .load_val ('0),
      .en       (accept_c),
      .tc_val   (K_LAST),
      .count    (k_q),
      .tc_c     (k_tc_c)
   );

   assign mmu_cycle = step_q;
   assign res_sel   = k_q[2:1];
   assign res_hi    = k_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         clear     <= 1'b0;
         mmu_en    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clear     <= clear_d;
         mmu_en    <= mmu_en_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
         done      <= done_d;
         overrun   <= overrun_d;
      end
   end

   // Next state plus next values of the registered status outputs.
   always_comb begin
      state_d   = state_q;
      overrun_d = overrun;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (load_en) begin
               state_d   = S_LOAD;
               overrun_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (load_en && addr_tc_c) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_COMPUTE;
            if (load_en) overrun_d = 1'b1;
         end
         S_COMPUTE: begin
            if (step_tc_c) state_d = S_OUTPUT;
            if (load_en) overrun_d = 1'b1;
         end
         S_OUTPUT: begin
            if (out_ready && k_tc_c) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            if (load_en) overrun_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      clear_d     = (state_d == S_CLEAR);
      mmu_en_d    = (state_d == S_COMPUTE);
      out_valid_d = (state_d == S_OUTPUT);
      busy_d      = (state_d != S_IDLE);
   end

endmodule

// File: doc/tpu_sequencer.md
# tpu_sequencer

Central sequencer for the 2x2 systolic TPU. It replaces the free-running load/compute counter with an explicit job state machine with five phases: accept 8 host bytes into the operand memory, pulse the PE clear, step the array for a fixed number of compute cycles, then stream 8 result bytes out under a valid/ready handshake. It sits between the host pins and the memory, feeder and systolic array. It drives their address, enable, cycle and result-select controls and holds no datapath values itself.

## Interface
Parameters:
- COMPUTE_CYCLES, default 5: number of mmu_en cycles per job, legal range 2..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load_en  in  1  host byte strobe; one operand byte is present on the data pins in each cycle it is high
- keep_w  in  1  reuse the stored weights for this job; ignored unless WEIGHT_REUSE_EN is defined
- out_ready  in  1  host accepts the current result byte
- mem_we  out  1  memory write enable
- mem_addr  out  3  memory address; 0-3 are weights, 4-7 are inputs
- clear  out  1  PE accumulator clear pulse
- mmu_en  out  1  systolic array / feeder enable
- mmu_cycle  out  3  compute step index
- res_sel  out  2  result select: 0=c00, 1=c01, 2=c10, 3=c11
- res_hi  out  1  0 = result bits [7:0], 1 = {4'b0, bits [11:8]}
- out_valid  out  1  a result byte is presented
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result byte is accepted
- overrun  out  1  sticky flag: load_en was seen while in CLEAR, COMPUTE or OUTPUT

## Operation
- States: IDLE, LOAD, CLEAR, COMPUTE, OUTPUT.
- mem_we = load_en while in IDLE or LOAD, combinational. mem_addr comes from the registered byte counter. load_en in any other state writes nothing and sets overrun.
- IDLE:
  - A load_en cycle writes the first byte at the start address and moves to LOAD.
  - The start address is 0. It is 4 when the macro is enabled, keep_w=1 and w_valid=1.
  - keep_w is sampled only on this cycle.
  - overrun clears on this cycle.
- LOAD:
  - Each load_en cycle writes one byte and increments the address.
  - A load_en low cycle is a stall: the address holds and there is no timeout.
  - The write to address 7 moves to CLEAR and sets w_valid.
- CLEAR: one cycle with clear=1 and mmu_cycle=0, then COMPUTE.
- COMPUTE: mmu_en=1 and mmu_cycle counts 0..COMPUTE_CYCLES-1, one per cycle, then OUTPUT.
- OUTPUT:
  - out_valid=1. The byte index k runs 0..7, with res_sel=k[2:1] and res_hi=k[0].
  - Byte order: c00 lo, c00 hi, c01 lo, c01 hi, then c10 and c11 in the same pattern.
  - k advances on out_valid && out_ready. res_sel and res_hi stay stable while out_ready is low.
  - Accepting k=7 moves to IDLE with done=1 for that one IDLE cycle.
- Reset (asynchronous, any state): state IDLE, all counters 0, w_valid 0, and every output 0.

## Timing
- All outputs are registered except mem_we.
- Let N be the cycle of the last load byte:
  - clear=1 at N+1.
  - mmu_en=1 from N+2 to N+1+COMPUTE_CYCLES.
  - First out_valid at N+2+COMPUTE_CYCLES.
- With out_ready held high, the job ends after 8 output cycles and done fires in the following cycle.
- In the done cycle the state is IDLE, so a load_en in that same cycle is accepted as byte 0 of the next job. This gives back-to-back jobs with zero bubble.
- A simultaneous out_ready and reset: reset wins.

## Configuration
- WEIGHT_REUSE_EN defined:
  - keep_w=1 with w_valid=1 skips addresses 0-3, so a job needs only 4 load bytes.
  - keep_w=1 with w_valid=0 falls back to a full 8-byte load.
- WEIGHT_REUSE_EN undefined: keep_w is ignored, w_valid is not implemented, and every job loads 8 bytes.

## Structure
- Shared package tpu_pkg holds:
  - the state enum;
  - W_BASE=0, IN_BASE=4, LAST_ADDR=7, OUT_BYTES=8.
- One sub-module is natural: tpu_seq_counter, a 3-bit counter with load, enable and terminal-count outputs. It is instantiated three times: byte address, compute step and output index.

## Test plan
- Full job: 8 load bytes with weights [1,2,3,4] and inputs [5,6,7,8], out_ready=1.
  - mem_addr runs 0..7; clear is seen 1 cycle later; mmu_en lasts 5 cycles.
  - 8 bytes are output with res_sel/res_hi following 0/0, 0/1, 1/0, ... 3/1.
  - done fires exactly once.
- Load stall: load_en low for 3 cycles after byte 2 → the address holds at 3 and no state change occurs; the remaining bytes complete normally.
- Output backpressure: out_ready low for 4 cycles at k=3 → res_sel=1 and res_hi=1 stay stable, out_valid stays high, done is delayed by 4 cycles.
- Back-to-back: a new load_en in the done cycle → mem_addr=0 is written and the next job completes.
- Overrun and reset:
  - load_en during COMPUTE → overrun=1 and mem_we=0; overrun clears on the next job start.
  - Asserting rst_n=0 mid-OUTPUT immediately drives all outputs to 0.
- WEIGHT_REUSE_EN:
  - keep_w=1 on the first job after reset → 8 bytes are loaded.
  - keep_w=1 on the second job → it starts at address 4, and clear fires 4 cycles after the start.
